// File: rtl/mcycle_alu_seq.sv
// Multi-cycle unsigned multiply / restoring divide. The shared ALU adder does one step per cycle.
// Hi/Lo hold the product during a multiply; the same registers hold R/Q during a divide.
module mcycle_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALU_Src_A,
  output logic [WIDTH-1:0] ALU_Src_B,
  output logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic [3:0]       ALU_Flags
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0010;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WIDTH-1:0] res1_q, res1_d, res2_q, res2_d;
  logic             op_q, op_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             carry;
  logic             ok;
  logic [WIDTH-1:0] shl_a;
  logic             unused_flags;

  assign carry        = ALU_Flags[1];
  assign unused_flags = ^{ALU_Flags[3:2], ALU_Flags[0]};
  // A partial remainder with its top bit set already exceeds any divisor.
  assign shl_a        = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign ok           = hi_q[WIDTH-1] | carry;

  assign Busy    = (state_q == ST_RUN);
  assign Done    = done_q;
  assign Result1 = res1_q;
  assign Result2 = res2_q;

  always_comb begin
    ALU_Src_A   = '0;
    ALU_Src_B   = '0;
    ALU_Control = OP_ADD;
    if (state_q == ST_RUN) begin
      ALU_Src_B = m_q;
      if (op_q) begin
        ALU_Src_A   = shl_a;
        ALU_Control = OP_SUB;
      end else begin
        ALU_Src_A   = hi_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (Start) begin
        op_d    = MCycleOp;
        hi_d    = '0;
        lo_d    = Operand1;
        m_d     = Operand2;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    end else begin
      if (op_q) begin
        hi_d = ok ? ALU_Result : shl_a;
        lo_d = {lo_q[WIDTH-2:0], ok};
      end else if (lo_q[0]) begin
        {hi_d, lo_d} = {carry, ALU_Result, lo_q[WIDTH-1:1]};
      end else begin
        {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        res1_d  = lo_d;
        res2_d  = hi_d;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/mcycle_alu_seq.md
Name: mcycle_alu_seq

Overview:
- Multi-cycle multiply/divide sequencer. It reuses the shared 32-bit ALU adder/subtractor iteratively instead of adding a dedicated multiplier or divider.
- Sits beside the ALU in the processor datapath and drives its operand and control inputs while Busy is high.
- Performs unsigned shift-and-add multiply and unsigned restoring divide, one ALU operation per cycle.
- Outside Busy, the datapath mux returns ALU ownership to the decoder.

Parameters:
- WIDTH, 32, operand width; must equal the ALU width (32). Other values are unsupported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled only when not Busy.
- MCycleOp  in  1  0 = multiply, 1 = divide.
- Operand1  in  WIDTH  multiplicand / dividend.
- Operand2  in  WIDTH  multiplier / divisor.
- Result1  out  WIDTH  product low half / quotient.
- Result2  out  WIDTH  product high half / remainder.
- Busy  out  1  operation in progress; datapath mux selects this block's ALU drive.
- Done  out  1  one-cycle pulse when results become valid.
- ALU_Src_A  out  WIDTH  to ALU Src_A.
- ALU_Src_B  out  WIDTH  to ALU Src_B.
- ALU_Control  out  4  to ALU ALUControl.
- ALU_Result  in  WIDTH  from ALU ALUResult.
- ALU_Flags  in  4  from ALU ALUFlags {N,Z,C,V}; only C (bit 1) is used.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; Busy=0; Done=0; Result1=Result2=0; counter=0; internal registers=0.
- ALU opcodes used:
  - Multiply: 4'b0100 (add); C = carry-out.
  - Divide: 4'b0010 (A-B); C=1 means no borrow.
  - The integrator ties the ALU carry inputs to 0; these opcodes ignore them.
- ALU_* outputs are driven combinationally from internal registers.
- When not Busy: ALU_Src_A=ALU_Src_B=0 and ALU_Control=4'b0100.
- States:
  - IDLE: on Start=1 at a rising edge, latch the operation.
    - Multiply: Hi=0, Lo=Operand1, M=Operand2, Op=0.
    - Divide: R=0, Q=Operand1, D=Operand2, Op=1.
    - Set counter=0, Busy=1, go RUN.
  - RUN, multiply: drive Src_A=Hi, Src_B=M, control 0100. Each edge:
    - if Lo[0]=1: {Hi,Lo} <= {C, ALU_Result, Lo[WIDTH-1:1]};
    - else: {Hi,Lo} <= {1'b0, Hi, Lo[WIDTH-1:1]}.
  - RUN, divide: A' = {R[WIDTH-2:0], Q[WIDTH-1]}; drive Src_A=A', Src_B=D, control 0010. ok = R[WIDTH-1] | C. Each edge:
    - R <= ok ? ALU_Result : A';
    - Q <= {Q[WIDTH-2:0], ok}.
  - Counter increments each RUN edge. On the edge where counter==WIDTH-1:
    - load Result1 = Lo/Q and Result2 = Hi/R (post-update values);
    - Busy=0, Done=1, go IDLE.
- Latency: Start sampled at edge k; Busy high for cycles k+1..k+WIDTH; Done=1 and Results valid after edge k+WIDTH.
- Results hold until the next completion or reset.
- Done deasserts after exactly one cycle.
- Start while Busy: ignored; no re-latch, no queueing.
- Start asserted in the Done cycle (state IDLE): accepted normally.
- Start held high continuously: back-to-back operations, one every WIDTH+1 cycles.
- Operand1/Operand2/MCycleOp changes while Busy have no effect.
- Divide by zero (no special case): Result1=all ones, Result2=dividend.
- Multiply by zero: result 0 after full latency; no early termination.
- Reset mid-operation: aborts immediately; Results cleared to 0; no Done pulse.

Test Plan:
- Multiply 7 × 6: Start one cycle -> Busy high 32 cycles; Done pulse; Result1=0x0000002A, Result2=0.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001 (carry path exercised every iteration).
- Divide 100 / 7 -> Result1=14, Result2=2. Divide 0x80000000 / 1 -> Result1=0x80000000, Result2=0.
- Divide 0x1234 / 0 -> Result1=0xFFFFFFFF, Result2=0x00001234, normal 32-cycle latency.
- Start re-pulsed with different operands at Busy cycle 10 -> ignored; original result returned; then Start in Done cycle -> new op accepted, Busy the next cycle.
- RESET asserted asynchronously mid-cycle at Busy cycle 15 -> Busy, Done, Results go 0 immediately; after release a new multiply 3 × 5 yields 15.
